// File: rtl/stream_byte_swap.sv
// AXI-Stream endianness converter: network-order beats in, host-order beats out.
// Two-entry skid buffer, registered outputs, keep-legality check and packet counter.
module stream_byte_swap #(
    parameter int unsigned N     = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [8*N-1:0]   s_tdata,
    input  logic [N-1:0]     s_tkeep,
    input  logic             s_tlast,
    input  logic             s_tvalid,
    output logic             s_tready,
    output logic [8*N-1:0]   m_tdata,
    output logic [N-1:0]     m_tkeep,
    output logic             m_tlast,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic [CNT_W-1:0] pkt_count,
    output logic             keep_err
);

    logic [8*N-1:0]   out_data_q, out_data_d, skid_data_q, skid_data_d, swp_data;
    logic [N-1:0]     out_keep_q, out_keep_d, skid_keep_q, skid_keep_d, swp_keep;
    logic             out_last_q, out_last_d, skid_last_q, skid_last_d;
    logic             out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
    logic             s_ready_q, s_ready_d;
    logic [CNT_W-1:0] pkt_count_q, pkt_count_d;
    logic             keep_err_q, keep_err_d;
    logic [N-1:0]     keep_inv;
    logic             in_xfer, out_xfer, keep_legal;

    assign in_xfer  = s_tvalid && s_ready_q;
    assign out_xfer = out_valid_q && m_tready;

    always_comb begin
        swp_data = '0;
        swp_keep = '0;
        for (int i = 0; i < int'(N); i++) begin
            swp_data[8*i +: 8] = s_tdata[8*(int'(N)-1-i) +: 8];
            swp_keep[i]        = s_tkeep[int'(N)-1-i];
        end
    end

    // A last-beat keep is legal when its inverse is a low-aligned run of ones.
    always_comb begin
        keep_inv = ~s_tkeep;
        if (s_tlast) begin
            keep_legal = (s_tkeep != '0) && ((keep_inv & (keep_inv + 1'b1)) == '0);
        end else begin
            keep_legal = (s_tkeep == '1);
        end
    end

    always_comb begin
        out_data_d   = out_data_q;
        out_keep_d   = out_keep_q;
        out_last_d   = out_last_q;
        out_valid_d  = out_valid_q;
        skid_data_d  = skid_data_q;
        skid_keep_d  = skid_keep_q;
        skid_last_d  = skid_last_q;
        skid_valid_d = skid_valid_q;
        pkt_count_d  = pkt_count_q;
        keep_err_d   = keep_err_q;

        if (!out_valid_q || out_xfer) begin
            if (skid_valid_q) begin
                out_data_d   = skid_data_q;
                out_keep_d   = skid_keep_q;
                out_last_d   = skid_last_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (in_xfer) begin
                out_data_d  = swp_data;
                out_keep_d  = swp_keep;
                out_last_d  = s_tlast;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_xfer) begin
            skid_data_d  = swp_data;
            skid_keep_d  = swp_keep;
            skid_last_d  = s_tlast;
            skid_valid_d = 1'b1;
        end

        s_ready_d = !skid_valid_d;

        if (out_xfer && out_last_q) begin
            pkt_count_d = pkt_count_q + 1'b1;
        end
        if (in_xfer && !keep_legal) begin
            keep_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q   <= '0;
            out_keep_q   <= '0;
            out_last_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            skid_data_q  <= '0;
            skid_keep_q  <= '0;
            skid_last_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            s_ready_q    <= 1'b0;
            pkt_count_q  <= '0;
            keep_err_q   <= 1'b0;
        end else begin
            out_data_q   <= out_data_d;
            out_keep_q   <= out_keep_d;
            out_last_q   <= out_last_d;
            out_valid_q  <= out_valid_d;
            skid_data_q  <= skid_data_d;
            skid_keep_q  <= skid_keep_d;
            skid_last_q  <= skid_last_d;
            skid_valid_q <= skid_valid_d;
            s_ready_q    <= s_ready_d;
            pkt_count_q  <= pkt_count_d;
            keep_err_q   <= keep_err_d;
        end
    end

    assign s_tready  = s_ready_q;
    assign m_tdata   = out_data_q;
    assign m_tkeep   = out_keep_q;
    assign m_tlast   = out_last_q;
    assign m_tvalid  = out_valid_q;
    assign pkt_count = pkt_count_q;
    assign keep_err  = keep_err_q;

endmodule

// File: tb/tb_stream_byte_swap.sv
// Directed bench for stream_byte_swap with N=4 and a 2-bit packet counter.
module tb_stream_byte_swap;

    localparam int unsigned N     = 4;
    localparam int unsigned CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [8*N-1:0]   s_tdata;
    logic [N-1:0]     s_tkeep;
    logic             s_tlast;
    logic             s_tvalid;
    logic             s_tready;
    logic [8*N-1:0]   m_tdata;
    logic [N-1:0]     m_tkeep;
    logic             m_tlast;
    logic             m_tvalid;
    logic             m_tready;
    logic [CNT_W-1:0] pkt_count;
    logic             keep_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stream_byte_swap #(.N(N), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .s_tdata  (s_tdata),
        .s_tkeep  (s_tkeep),
        .s_tlast  (s_tlast),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .m_tdata  (m_tdata),
        .m_tkeep  (m_tkeep),
        .m_tlast  (m_tlast),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .pkt_count(pkt_count),
        .keep_err (keep_err)
    );

    // Advance one rising edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] d, input logic [3:0] k, input logic l);
        s_tdata  = d;
        s_tkeep  = k;
        s_tlast  = l;
        s_tvalid = 1'b1;
    endtask

    initial begin
        rst      = 1'b1;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tlast  = 1'b0;
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        tick();
        tick();
        check("rst_mvalid", 32'(m_tvalid), 32'd0);
        check("rst_sready", 32'(s_tready), 32'd0);
        check("rst_mdata", m_tdata, 32'd0);
        check("rst_mkeep", 32'(m_tkeep), 32'd0);
        check("rst_pkt", 32'(pkt_count), 32'd0);
        check("rst_kerr", 32'(keep_err), 32'd0);
        rst = 1'b0;
        tick();
        check("rst_release_sready", 32'(s_tready), 32'd1);

        // Single full beat
        drive(32'h11223344, 4'b1111, 1'b1);
        tick();
        s_tvalid = 1'b0;
        check("t1_mvalid", 32'(m_tvalid), 32'd1);
        check("t1_mdata", m_tdata, 32'h44332211);
        check("t1_mkeep", 32'(m_tkeep), 32'hF);
        check("t1_mlast", 32'(m_tlast), 32'd1);
        tick();
        check("t1_pkt", 32'(pkt_count), 32'd1);
        check("t1_drain", 32'(m_tvalid), 32'd0);

        // Partial last beat
        drive(32'hAABB0000, 4'b1100, 1'b1);
        tick();
        s_tvalid = 1'b0;
        check("t2_mdata", m_tdata, 32'h0000BBAA);
        check("t2_mkeep", 32'(m_tkeep), 32'h3);
        tick();
        check("t2_kerr", 32'(keep_err), 32'd0);
        check("t2_pkt", 32'(pkt_count), 32'd2);

        // Eight back-to-back beats
        for (int i = 0; i < 8; i++) begin
            drive({8'(i), 8'h10, 8'h20, 8'(i + 1)}, 4'b1111, i == 7);
            tick();
            check("t3_sready", 32'(s_tready), 32'd1);
            check("t3_mvalid", 32'(m_tvalid), 32'd1);
            check("t3_mdata", m_tdata, {8'(i + 1), 8'h20, 8'h10, 8'(i)});
        end
        s_tvalid = 1'b0;
        tick();
        check("t3_pkt", 32'(pkt_count), 32'd3);
        check("t3_kerr", 32'(keep_err), 32'd0);

        // Backpressure: fill OUT and SKID, then drain
        m_tready = 1'b0;
        drive(32'hA0A1A2A3, 4'b1111, 1'b0);
        tick();
        check("t4_sready_a", 32'(s_tready), 32'd1);
        check("t4_out_a", m_tdata, 32'hA3A2A1A0);
        drive(32'hB0B1B2B3, 4'b1111, 1'b0);
        tick();
        check("t4_sready_b", 32'(s_tready), 32'd0);
        drive(32'hC0C1C2C3, 4'b1111, 1'b1);
        tick();
        check("t4_sready_hold", 32'(s_tready), 32'd0);
        check("t4_stable_a", m_tdata, 32'hA3A2A1A0);
        check("t4_stable_last", 32'(m_tlast), 32'd0);
        m_tready = 1'b1;
        tick();
        check("t4_out_b", m_tdata, 32'hB3B2B1B0);
        check("t4_sready_up", 32'(s_tready), 32'd1);
        tick();
        s_tvalid = 1'b0;
        check("t4_out_c", m_tdata, 32'hC3C2C1C0);
        check("t4_last_c", 32'(m_tlast), 32'd1);
        tick();
        check("t4_empty", 32'(m_tvalid), 32'd0);
        check("t4_pkt_wrap", 32'(pkt_count), 32'd0);

        // Illegal keep on a non-last beat
        drive(32'h11223344, 4'b0111, 1'b0);
        tick();
        check("t5_mdata", m_tdata, 32'h44332211);
        check("t5_mkeep", 32'(m_tkeep), 32'hE);
        check("t5_kerr", 32'(keep_err), 32'd1);
        drive(32'h55667788, 4'b1111, 1'b1);
        tick();
        s_tvalid = 1'b0;
        tick();
        check("t5_kerr_sticky", 32'(keep_err), 32'd1);
        check("t5_pkt", 32'(pkt_count), 32'd1);

        // Counter wrap from a clean reset
        rst = 1'b1;
        tick();
        check("t6_kerr_clr", 32'(keep_err), 32'd0);
        check("t6_pkt_clr", 32'(pkt_count), 32'd0);
        rst = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) begin
            drive(32'(k), 4'b1111, 1'b1);
            tick();
            s_tvalid = 1'b0;
            tick();
            check("t6_pkt_seq", 32'(pkt_count), 32'((k + 1) % 4));
        end

        // Reset while OUT holds a beat
        m_tready = 1'b0;
        drive(32'hDEADBEEF, 4'b1111, 1'b1);
        tick();
        s_tvalid = 1'b0;
        check("t7_full", 32'(m_tvalid), 32'd1);
        rst = 1'b1;
        tick();
        check("t7_mvalid", 32'(m_tvalid), 32'd0);
        check("t7_pkt", 32'(pkt_count), 32'd0);
        check("t7_sready", 32'(s_tready), 32'd0);
        check("t7_mdata", m_tdata, 32'd0);
        rst = 1'b0;
        tick();
        check("t7_sready_up", 32'(s_tready), 32'd1);
        check("t7_no_flush", 32'(m_tvalid), 32'd0);

        // Last-beat keep legality: 1000 legal, 1010 and 0000 illegal
        m_tready = 1'b1;
        drive(32'h12000000, 4'b1000, 1'b1);
        tick();
        check("t8_mkeep", 32'(m_tkeep), 32'h1);
        check("t8_mdata", m_tdata, 32'h00000012);
        s_tvalid = 1'b0;
        tick();
        check("t8_kerr_legal", 32'(keep_err), 32'd0);
        drive(32'h12003400, 4'b1010, 1'b1);
        tick();
        s_tvalid = 1'b0;
        check("t8_kerr_gap", 32'(keep_err), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        drive(32'h0, 4'b0000, 1'b1);
        tick();
        s_tvalid = 1'b0;
        check("t8_kerr_zero", 32'(keep_err), 32'd1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_byte_swap.md
Name: stream_byte_swap

Overview:
- Registered AXI-Stream endianness converter sitting between the network-facing datapath and host-facing logic.
- Each beat arrives in network order: packet byte 0 in the most-significant lane, keep bits MSB-aligned. Each beat leaves in host order: byte 0 in lane 0, keep LSB-aligned.
- A two-entry skid buffer gives full throughput with all outputs registered.
- The block also checks keep-mask legality and counts packets.

Parameters:
- N, 32, data width in bytes; must be at least 1.
- CNT_W, 16, width of the packet counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_tdata  in  8*N  input beat data, network order
- s_tkeep  in  N  input byte enables, MSB-aligned
- s_tlast  in  1  last beat of packet
- s_tvalid  in  1  input valid
- s_tready  out  1  input ready
- m_tdata  out  8*N  output data, host order
- m_tkeep  out  N  output byte enables, LSB-aligned
- m_tlast  out  1  last beat of packet
- m_tvalid  out  1  output valid
- m_tready  in  1  output ready
- pkt_count  out  CNT_W  packets completed at the output
- keep_err  out  1  sticky keep-legality error flag

Behaviour:
- Transform:
  - m_tdata byte i = input byte N-1-i.
  - m_tkeep bit i = input keep bit N-1-i.
  - tlast passes through unchanged.
  - Swapped data and keep are computed combinationally from s_* and captured into registers.
- Handshake:
  - An input transfer occurs when s_tvalid && s_tready.
  - An output transfer occurs when m_tvalid && m_tready.
  - Once m_tvalid is asserted, m_tdata, m_tkeep and m_tlast stay stable until the output transfer.
- Storage: an output register (OUT) plus a skid register (SKID).
  - s_tready is a register and equals !SKID.valid.
  - OUT empty, or OUT transferring this cycle: the input beat loads into OUT.
  - OUT full and stalled (m_tready=0) while s_tready=1: the input beat loads into SKID and s_tready drops next cycle.
  - OUT transferring while SKID is full: SKID moves to OUT, SKID empties, and s_tready rises next cycle.
  - Beats are never dropped, duplicated or reordered.
- Latency: 1 cycle from input transfer to m_tvalid when OUT is empty. Sustained throughput is 1 beat/cycle while m_tready=1.
- Simultaneous input and output transfer with SKID empty: OUT reloads with the new beat, and m_tvalid stays 1.
- pkt_count:
  - Increments by 1 on each output transfer with m_tlast=1.
  - Wraps modulo 2^CNT_W with no saturation.
- keep_err: set on an input transfer in either of these cases:
  - s_tlast=0 and s_tkeep is not all ones.
  - s_tlast=1 and s_tkeep is not a contiguous MSB-aligned run of at least one bit. All-zero keep is illegal.
- keep_err is sticky until reset. The offending beat is still forwarded unmodified by the check.
- Reset (synchronous, rst=1 at a rising edge):
  - m_tvalid=0, s_tready=0, OUT and SKID invalid.
  - m_tdata=0, m_tkeep=0, m_tlast=0.
  - pkt_count=0, keep_err=0.
  - s_tready goes to 1 on the first edge with rst=0.
- Reset mid-packet discards OUT and SKID contents. The partial packet is not counted, and no downstream flush beat is generated.
- N=1: the swap is the identity; keep rules reduce to keep==1.

Test Plan:
- N=4, m_tready=1, one beat data=0x11223344, keep=4'b1111, last=1 -> after 1 cycle m_tdata=0x44332211, m_tkeep=4'b1111, m_tlast=1; pkt_count=1.
- N=4, last beat keep=4'b1100, data=0xAABB0000 -> m_tdata=0x0000BBAA, m_tkeep=4'b0011; keep_err stays 0.
- Stream 8 back-to-back beats with m_tready=1 -> 8 output beats on consecutive cycles, in order, with s_tready constantly 1.
- Hold m_tready=0 while sending 3 beats -> OUT and SKID fill and s_tready=0 after the second accept. Release m_tready -> all beats emerge in order with no loss or duplication.
- Non-last beat with keep=4'b0111 -> beat forwarded swapped with keep 4'b1110 and keep_err=1; keep_err remains set until rst.
- CNT_W=2, 5 single-beat packets -> pkt_count sequence 1,2,3,0,1. Assert rst with OUT full -> next cycle m_tvalid=0, pkt_count=0, s_tready=0, then s_tready=1.
